bcd_timer_scan: RTL and testbench

//  Parametrised BCD stopwatch/countdown timer with multiplexed 7-segment drive, N digits.

---
 rtl/bcd_timer_scan.sv | 165 ++++++++++++++++
 tb/tb_bcd_timer_scan.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_timer_scan.sv
// bcd_timer_scan: N-digit BCD up/down timer with synchronised start/stop/clear/load
// controls and a registered, polarity-selectable multiplexed 7-segment scan.
module bcd_timer_scan #(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int SCAN_DIV   = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    inv,
    input  logic                    mode,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    clear,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] preset,
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic [4*NUM_DIGITS-1:0] count,
    output logic                    running,
    output logic                    done,
    output logic                    wrap
);
    localparam int CW = 4 * NUM_DIGITS;
    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
    localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSED, DONE} state_e;

    state_e                st_q, st_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [PW-1:0]         pre_q, pre_d;
    logic                  mode_q, mode_d;
    logic                  wrap_q, wrap_d;
    logic [3:0]            s1_q, s2_q;
    logic [2:0]            s3_q;
    logic [2:0]            edg;
    logic [SW-1:0]         sc_q;
    logic [IW-1:0]         idx_q;
    logic [7:0]            seg_q;
    logic [NUM_DIGITS-1:0] dig_q;

    function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
        logic c;
        c = 1'b1;
        bcd_inc = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (c) begin
                c = bcd_inc[4*i +: 4] == 4'd9;
                bcd_inc[4*i +: 4] = c ? 4'd0 : bcd_inc[4*i +: 4] + 4'd1;
            end
        end
    endfunction

    function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
        logic b;
        b = 1'b1;
        bcd_dec = v;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (b) begin
                b = bcd_dec[4*i +: 4] == 4'd0;
                bcd_dec[4*i +: 4] = b ? 4'd9 : bcd_dec[4*i +: 4] - 4'd1;
            end
        end
    endfunction

    function automatic logic [CW-1:0] clamp9(input logic [CW-1:0] v);
        for (int i = 0; i < NUM_DIGITS; i++)
            clamp9[4*i +: 4] = v[4*i +: 4] > 4'd9 ? 4'd9 : v[4*i +: 4];
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0:    seg7 = 7'h3F;
            4'd1:    seg7 = 7'h06;
            4'd2:    seg7 = 7'h5B;
            4'd3:    seg7 = 7'h4F;
            4'd4:    seg7 = 7'h66;
            4'd5:    seg7 = 7'h6D;
            4'd6:    seg7 = 7'h7D;
            4'd7:    seg7 = 7'h07;
            4'd8:    seg7 = 7'h7F;
            4'd9:    seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    // rising edges of {load, stop, start}; clear acts on its synchronised level s2_q[2]
    assign edg = {s2_q[3], s2_q[1:0]} & ~s3_q;

    always_comb begin
        st_d   = st_q;
        cnt_d  = cnt_q;
        pre_d  = pre_q;
        mode_d = mode_q;
        wrap_d = 1'b0;
        if (s2_q[2]) begin
            st_d  = IDLE;
            cnt_d = '0;
            pre_d = '0;
        end else if (edg[1]) begin
            st_d = st_q == RUN ? PAUSED : st_q;
        end else if (edg[0] && st_q != RUN) begin
            mode_d = mode;
            st_d   = (mode && cnt_q == '0) ? DONE : RUN;
            pre_d  = st_q == IDLE ? '0 : pre_q;
        end else if (edg[2] && st_q != RUN) begin
            cnt_d = clamp9(preset);
            pre_d = '0;
            st_d  = st_q == DONE ? IDLE : st_q;
        end else if (st_q == RUN) begin
            if (pre_q == PW'(TICK_DIV - 1)) begin
                pre_d = '0;
                if (mode_q) begin
                    cnt_d = bcd_dec(cnt_q);
                    st_d  = cnt_d == '0 ? DONE : RUN;
                end else begin
                    cnt_d  = bcd_inc(cnt_q);
                    wrap_d = cnt_d == '0;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            pre_q  <= '0;
            mode_q <= 1'b0;
            wrap_q <= 1'b0;
            s1_q   <= '0;
            s2_q   <= '0;
            s3_q   <= '0;
            sc_q   <= '0;
            idx_q  <= '0;
            seg_q  <= 8'h00;
            dig_q  <= '0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            pre_q  <= pre_d;
            mode_q <= mode_d;
            wrap_q <= wrap_d;
            s1_q   <= {load, clear, stop, start};
            s2_q   <= s1_q;
            s3_q   <= {s2_q[3], s2_q[1:0]};
            sc_q   <= sc_q == SW'(SCAN_DIV - 1) ? '0 : sc_q + 1'b1;
            if (sc_q == SW'(SCAN_DIV - 1))
                idx_q <= idx_q == IW'(NUM_DIGITS - 1) ? '0 : idx_q + 1'b1;
            dig_q  <= (NUM_DIGITS'(1) << idx_q) ^ {NUM_DIGITS{inv}};
            seg_q  <= {1'b0, seg7(cnt_q[4*idx_q +: 4])} ^ {8{inv}};
        end
    end

    assign count   = cnt_q;
    assign running = st_q == RUN;
    assign done    = st_q == DONE;
    assign wrap    = wrap_q;
    assign segment = seg_q;
    assign digit   = dig_q;
endmodule

// File: tb/tb_bcd_timer_scan.sv
// tb_bcd_timer_scan: directed scenarios plus random control traffic; a decimal
// reference model queues expected outputs each clock, a monitor pops and compares.
module tb_bcd_timer_scan;
    localparam int ND = 4;
    localparam int TD = 4;
    localparam int SD = 2;
    localparam int MAXV = 10000;
    localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_DONE = 3;
    localparam logic [6:0] SEG [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                        7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    typedef struct packed {
        logic [15:0] cnt;
        logic        run;
        logic        dn;
        logic        wr;
        logic [7:0]  seg;
        logic [3:0]  dig;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        inv = 1'b0, mode = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0, load = 1'b0;
    logic [15:0] preset = '0;
    logic [7:0]  segment;
    logic [3:0]  digit;
    logic [15:0] count;
    logic        running, done, wrap;

    int   tests = 0;
    int   fails = 0;
    exp_t sbq[$];

    int         m_st, m_cnt, m_pre, m_cyc;
    logic       m_mode, m_wrap;
    logic [2:0] h_sta, h_stp, h_ld, h_clr;

    bcd_timer_scan #(.NUM_DIGITS(ND), .TICK_DIV(TD), .SCAN_DIV(SD)) dut (
        .clk(clk), .rst_n(rst_n), .inv(inv), .mode(mode), .start(start), .stop(stop),
        .clear(clear), .load(load), .preset(preset), .segment(segment), .digit(digit),
        .count(count), .running(running), .done(done), .wrap(wrap)
    );

    always #5 clk = ~clk;

    function automatic int p10(input int i);
        p10 = 1;
        repeat (i) p10 *= 10;
    endfunction

    function automatic logic [15:0] to_bcd(input int v);
        for (int i = 0; i < ND; i++) to_bcd[4*i +: 4] = 4'((v / p10(i)) % 10);
    endfunction

    function automatic int clampv(input logic [15:0] p);
        clampv = 0;
        for (int i = 0; i < ND; i++)
            clampv += (p[4*i +: 4] > 4'd9 ? 9 : int'(p[4*i +: 4])) * p10(i);
    endfunction

    // reference model: count kept as a plain decimal integer, scan slot derived from cycles since reset
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_st = S_IDLE;
            m_cnt = 0;
            m_pre = 0;
            m_cyc = 0;
            m_mode = 1'b0;
            m_wrap = 1'b0;
            h_sta = '0;
            h_stp = '0;
            h_ld = '0;
            h_clr = '0;
            sbq.delete();
        end else begin
            int   idx;
            exp_t e;
            logic st_e, sp_e, ld_e;
            idx = (m_cyc / SD) % ND;
            e.dig = 4'(1 << idx) ^ {4{inv}};
            e.seg = {1'b0, SEG[(m_cnt / p10(idx)) % 10]} ^ {8{inv}};
            m_cyc++;
            st_e = h_sta[1] && !h_sta[2];
            sp_e = h_stp[1] && !h_stp[2];
            ld_e = h_ld[1] && !h_ld[2];
            m_wrap = 1'b0;
            if (h_clr[1]) begin
                m_st = S_IDLE;
                m_cnt = 0;
                m_pre = 0;
            end else if (sp_e) begin
                if (m_st == S_RUN) m_st = S_PAUSED;
            end else if (st_e && m_st != S_RUN) begin
                if (m_st == S_IDLE) m_pre = 0;
                m_mode = mode;
                m_st = (mode && m_cnt == 0) ? S_DONE : S_RUN;
            end else if (ld_e && m_st != S_RUN) begin
                m_cnt = clampv(preset);
                m_pre = 0;
                if (m_st == S_DONE) m_st = S_IDLE;
            end else if (m_st == S_RUN) begin
                if (m_pre == TD - 1) begin
                    m_pre = 0;
                    if (m_mode) begin
                        m_cnt--;
                        if (m_cnt == 0) m_st = S_DONE;
                    end else begin
                        m_wrap = m_cnt == MAXV - 1;
                        m_cnt = (m_cnt + 1) % MAXV;
                    end
                end else begin
                    m_pre++;
                end
            end
            h_sta = {h_sta[1:0], start};
            h_stp = {h_stp[1:0], stop};
            h_ld  = {h_ld[1:0], load};
            h_clr = {h_clr[1:0], clear};
            e.cnt = to_bcd(m_cnt);
            e.run = m_st == S_RUN;
            e.dn  = m_st == S_DONE;
            e.wr  = m_wrap;
            sbq.push_back(e);
        end
    end

    always @(negedge clk) begin
        if (rst_n && sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            tests++;
            if ({count, running, done, wrap, segment, digit} !== e) begin
                fails++;
                $display("FAIL scoreboard t=%0t count=%h want %h run=%b want %b done=%b want %b wrap=%b want %b seg=%h want %h dig=%b want %b",
                         $time, count, e.cnt, running, e.run, done, e.dn, wrap, e.wr, segment, e.seg, digit, e.dig);
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        tests++;
        if (act !== want) begin
            fails++;
            $display("FAIL %s t=%0t got %h want %h", nm, $time, act, want);
        end
    endtask

    task automatic wait_dig(input logic [3:0] t);
        for (int i = 0; i < 20; i++) begin
            cyc(1);
            if (digit === t) break;
        end
        chk("scan_sync", {28'b0, digit}, {28'b0, t});
    endtask

    task automatic scan_seq(input logic [3:0] d0, input logic [7:0] g0, input logic [3:0] d1, input logic [7:0] g1,
                            input logic [3:0] d2, input logic [7:0] g2, input logic [3:0] d3, input logic [7:0] g3);
        wait_dig(d3);
        wait_dig(d0);
        chk("scan_seg0", {24'b0, segment}, {24'b0, g0});
        cyc(2);
        chk("scan_d1", {28'b0, digit}, {28'b0, d1});
        chk("scan_seg1", {24'b0, segment}, {24'b0, g1});
        cyc(2);
        chk("scan_d2", {28'b0, digit}, {28'b0, d2});
        chk("scan_seg2", {24'b0, segment}, {24'b0, g2});
        cyc(2);
        chk("scan_d3", {28'b0, digit}, {28'b0, d3});
        chk("scan_seg3", {24'b0, segment}, {24'b0, g3});
    endtask

    initial begin
        cyc(3);
        chk("reset", {1'b0, count, running, done, wrap, segment, digit}, 32'h0);
        rst_n = 1'b1;
        start = 1'b1;
        cyc(3);
        chk("start_running", {31'b0, running}, 32'd1);
        start = 1'b0;
        cyc(3);
        chk("pre_first_tick", {16'b0, count}, 32'h0000);
        cyc(1);
        chk("first_tick", {16'b0, count}, 32'h0001);
        cyc(36);
        chk("forty_clk", {16'b0, count}, 32'h0010);
        clear = 1'b1;
        cyc(3);
        chk("clear_idle", {15'b0, count, running}, 32'h0);
        clear = 1'b0;
        preset = 16'h9999;
        load = 1'b1;
        cyc(3);
        chk("load_9999", {16'b0, count}, 32'h9999);
        load = 1'b0;
        mode = 1'b0;
        start = 1'b1;
        cyc(3);
        chk("run_9999", {15'b0, count, running}, {15'b0, 16'h9999, 1'b1});
        start = 1'b0;
        cyc(3);
        chk("pre_wrap", {14'b0, count, running, wrap}, {14'b0, 16'h9999, 2'b10});
        cyc(1);
        chk("wrap", {14'b0, count, running, wrap}, {14'b0, 16'h0000, 2'b11});
        cyc(1);
        chk("wrap_one_clk", {31'b0, wrap}, 32'd0);
        clear = 1'b1;
        cyc(3);
        clear = 1'b0;
        preset = 16'h0002;
        load = 1'b1;
        cyc(3);
        chk("load_0002", {16'b0, count}, 32'h0002);
        load = 1'b0;
        mode = 1'b1;
        start = 1'b1;
        cyc(3);
        chk("down_running", {31'b0, running}, 32'd1);
        start = 1'b0;
        cyc(4);
        chk("down_0001", {16'b0, count}, 32'h0001);
        cyc(4);
        chk("down_done", {14'b0, count, running, done}, {14'b0, 16'h0000, 2'b01});
        start = 1'b1;
        cyc(3);
        chk("done_stays", {30'b0, running, done}, 32'd1);
        start = 1'b0;
        clear = 1'b1;
        cyc(3);
        chk("clear_done", {30'b0, running, done}, 32'd0);
        clear = 1'b0;
        mode = 1'b0;
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        cyc(8);
        stop = 1'b1;
        cyc(3);
        chk("paused", {15'b0, count, running}, {15'b0, 16'h0002, 1'b0});
        cyc(20);
        chk("frozen", {15'b0, count, running}, {15'b0, 16'h0002, 1'b0});
        stop = 1'b0;
        start = 1'b1;
        cyc(3);
        chk("resume", {15'b0, count, running}, {15'b0, 16'h0002, 1'b1});
        cyc(1);
        chk("resume_hold", {16'b0, count}, 32'h0002);
        cyc(1);
        chk("resume_tick", {16'b0, count}, 32'h0003);
        start = 1'b0;
        cyc(2);
        clear = 1'b1;
        start = 1'b1;
        cyc(3);
        chk("clear_beats_start", {15'b0, count, running}, 32'h0);
        clear = 1'b0;
        start = 1'b0;
        cyc(3);
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        cyc(2);
        stop = 1'b1;
        start = 1'b1;
        cyc(3);
        chk("stop_beats_start", {30'b0, running, done}, 32'd0);
        stop = 1'b0;
        start = 1'b0;
        preset = 16'h12C4;
        load = 1'b1;
        cyc(3);
        chk("clamp_C", {16'b0, count}, 32'h1294);
        load = 1'b0;
        preset = 16'h1234;
        cyc(1);
        load = 1'b1;
        cyc(3);
        load = 1'b0;
        chk("load_1234", {16'b0, count}, 32'h1234);
        scan_seq(4'b0001, 8'h66, 4'b0010, 8'h4F, 4'b0100, 8'h5B, 4'b1000, 8'h06);
        inv = 1'b1;
        scan_seq(4'b1110, 8'h99, 4'b1101, 8'hB0, 4'b1011, 8'hA4, 4'b0111, 8'hF9);
        inv = 1'b0;
        start = 1'b1;
        cyc(3);
        start = 1'b0;
        cyc(5);
        #1 rst_n = 1'b0;
        #1 chk("async_reset", {1'b0, count, running, done, wrap, segment, digit}, 32'h0);
        cyc(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) start = ~start;
            if ($urandom_range(0, 39) == 0) stop = ~stop;
            if ($urandom_range(0, 11) == 0) load = ~load;
            if (clear) clear = $urandom_range(0, 3) != 0;
            else clear = $urandom_range(0, 149) == 0;
            if ($urandom_range(0, 31) == 0) mode = 1'($urandom);
            if ($urandom_range(0, 63) == 0) inv = ~inv;
            if ($urandom_range(0, 7) == 0)
                case ($urandom_range(0, 2))
                    0: preset = 16'($urandom) & 16'h00FF;
                    1: preset = 16'h9990 | 16'($urandom_range(0, 15));
                    default: preset = 16'($urandom);
                endcase
            cyc(1);
        end
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
